mul4_fitness_scorer: RTL and testbench

MUL4_FITNESS_SCORER -- requirements
Module: mul4_fitness_scorer

---
 rtl/mul4_fitness_scorer.sv | 131 +++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer for a four-product 16x16 multiplier candidate: drives LFSR stimulus, checks responses, accumulates score.
// Optional FITNESS_BITCOUNT_EN scores matching bits (0..64 per vector) instead of matching lanes (0..4).
module mul4_fitness_scorer #(
   parameter int          NUM_VECTORS = 256,
   parameter int          SETTLE      = 1,
   parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] a1,
   output logic [15:0] a0,
   output logic [15:0] b1,
   output logic [15:0] b0,
   input  logic [15:0] y3,
   input  logic [15:0] y2,
   input  logic [15:0] y1,
   input  logic [15:0] y0,
   output logic        busy,
   output logic        done,
   output logic [23:0] score,
   output logic        perfect
);

`ifdef FITNESS_BITCOUNT_EN
   localparam int PER_VECTOR = 64;
`else
   localparam int PER_VECTOR = 4;
`endif
   localparam logic [23:0] MAX_SCORE = 24'(PER_VECTOR * NUM_VECTORS);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [12:0] VEC_LAST    = 13'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

   state_t      state;
   state_t      state_nx;
   logic [63:0] lfsr;
   logic [63:0] lfsr_nx;
   logic [3:0]  settle_cnt;
   logic [12:0] vec_cnt;
   logic [23:0] score_r;
   logic [15:0] g3, g2, g1, g0;
   logic [6:0]  vec_count;

   assign a1 = lfsr[63:48];
   assign a0 = lfsr[47:32];
   assign b1 = lfsr[31:16];
   assign b0 = lfsr[15:0];

   // Fibonacci taps 64,63,61,60 (1-based) map to bit indices 63,62,60,59.
   assign lfsr_nx = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};

   assign g3 = a1 * b1;
   assign g2 = a1 * b0;
   assign g1 = a0 * b1;
   assign g0 = a0 * b0;

`ifdef FITNESS_BITCOUNT_EN
   logic [63:0] same_bits;
   assign same_bits = ~{y3 ^ g3, y2 ^ g2, y1 ^ g1, y0 ^ g0};

   always_comb begin
      vec_count = '0;
      for (int i = 0; i < 64; i++) begin
         vec_count = vec_count + {6'd0, same_bits[i]};
      end
   end
`else
   always_comb begin
      vec_count = '0;
      vec_count = 7'(y3 == g3) + 7'(y2 == g2) + 7'(y1 == g1) + 7'(y0 == g0);
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = DRIVE;
         DRIVE:   if (settle_cnt == SETTLE_LAST) state_nx = SAMPLE;
         SAMPLE:  state_nx = (vec_cnt == VEC_LAST) ? FINISH : DRIVE;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The LFSR only moves at the end of SAMPLE, so stimulus is steady across DRIVE and SAMPLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr       <= SEED;
         settle_cnt <= '0;
         vec_cnt    <= '0;
         score_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr       <= SEED;
                  settle_cnt <= '0;
                  vec_cnt    <= '0;
                  score_r    <= '0;
               end
            end
            DRIVE: begin
               settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
            end
            SAMPLE: begin
               score_r <= score_r + {17'd0, vec_count};
               lfsr    <= lfsr_nx;
               vec_cnt <= vec_cnt + 13'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == FINISH);
   assign score   = score_r;
   assign perfect = (score_r == MAX_SCORE);

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Bench: five scorer instances with different candidates, expected run results queued and checked on done.
module tb_mul4_fitness_scorer;

`ifdef FITNESS_BITCOUNT_EN
   localparam int PER = 64;
`else
   localparam int PER = 4;
`endif
   localparam logic [63:0] DSEED = 64'h0000_0000_0000_0001;
   localparam logic [63:0] RSEED = 64'hDEAD_BEEF_1234_5678;
   localparam logic [63:0] XMASK = 64'h0001_0001_0001_0000;
   localparam int W = 52;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [4:0]  start_v;
   logic [4:0]  busy_v, done_v, perf_v;
   logic [63:0] s0, s1, s2, s3, s4;
   logic [63:0] r0, r1, r2, r3, r4;
   logic [23:0] sc0, sc1, sc2, sc3, sc4;
   logic [63:0] p2a, p2b, p3a, p3b;
   logic [63:0] mask_tab [16];

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- reference model ----------------
   function automatic logic [63:0] golden(input logic [63:0] s);
      logic [15:0] xa1, xa0, xb1, xb0, p3, p2, p1, p0;
      xa1 = s[63:48]; xa0 = s[47:32]; xb1 = s[31:16]; xb0 = s[15:0];
      p3 = xa1 * xb1; p2 = xa1 * xb0; p1 = xa0 * xb1; p0 = xa0 * xb0;
      return {p3, p2, p1, p0};
   endfunction

   function automatic logic [63:0] step(input logic [63:0] s);
      logic fb;
      fb = s[63] ^ s[62] ^ s[60] ^ s[59];
      return (s << 1) | {63'd0, fb};
   endfunction

   function automatic int vcount(input logic [63:0] g, input logic [63:0] y);
      int n = 0;
`ifdef FITNESS_BITCOUNT_EN
      for (int i = 0; i < 64; i++) if (g[i] == y[i]) n++;
`else
      for (int l = 0; l < 4; l++) if (g[l*16 +: 16] == y[l*16 +: 16]) n++;
`endif
      return n;
   endfunction

   function automatic int nv_of(input int id);
      case (id)
         0: return 256;
         1: return 100;
         2, 3: return 64;
         default: return 37;
      endcase
   endfunction

   function automatic int st_of(input int id);
      case (id)
         2: return 3;
         4: return 2;
         default: return 1;
      endcase
   endfunction

   // Score of a full run: walk the stimulus sequence and apply each candidate's error pattern.
   function automatic int model_score(input int id);
      logic [63:0] s, g, y;
      int sc = 0;
      s = (id == 4) ? RSEED : DSEED;
      for (int v = 0; v < nv_of(id); v++) begin
         g = golden(s);
         case (id)
            1: y = g ^ XMASK;
            4: y = g ^ mask_tab[s[3:0]];
            default: y = g;
         endcase
         sc += vcount(g, y);
         s = step(s);
      end
      return sc;
   endfunction

   // ---------------- candidates ----------------
   assign r0 = golden(s0);
   assign r1 = golden(s1) ^ XMASK;
   always @(posedge clk) begin
      p2a <= golden(s2); p2b <= p2a;
      p3a <= golden(s3); p3b <= p3a;
   end
   assign r2 = p2b;
   assign r3 = p3b;
   assign r4 = golden(s4) ^ mask_tab[s4[3:0]];

   // ---------------- DUTs ----------------
   mul4_fitness_scorer #(.NUM_VECTORS(256), .SETTLE(1)) u_ideal (
      .clk(clk), .rst(rst), .start(start_v[0]),
      .a1(s0[63:48]), .a0(s0[47:32]), .b1(s0[31:16]), .b0(s0[15:0]),
      .y3(r0[63:48]), .y2(r0[47:32]), .y1(r0[31:16]), .y0(r0[15:0]),
      .busy(busy_v[0]), .done(done_v[0]), .score(sc0), .perfect(perf_v[0]));
   mul4_fitness_scorer #(.NUM_VECTORS(100), .SETTLE(1)) u_xor (
      .clk(clk), .rst(rst), .start(start_v[1]),
      .a1(s1[63:48]), .a0(s1[47:32]), .b1(s1[31:16]), .b0(s1[15:0]),
      .y3(r1[63:48]), .y2(r1[47:32]), .y1(r1[31:16]), .y0(r1[15:0]),
      .busy(busy_v[1]), .done(done_v[1]), .score(sc1), .perfect(perf_v[1]));
   mul4_fitness_scorer #(.NUM_VECTORS(64), .SETTLE(3)) u_late3 (
      .clk(clk), .rst(rst), .start(start_v[2]),
      .a1(s2[63:48]), .a0(s2[47:32]), .b1(s2[31:16]), .b0(s2[15:0]),
      .y3(r2[63:48]), .y2(r2[47:32]), .y1(r2[31:16]), .y0(r2[15:0]),
      .busy(busy_v[2]), .done(done_v[2]), .score(sc2), .perfect(perf_v[2]));
   mul4_fitness_scorer #(.NUM_VECTORS(64), .SETTLE(1)) u_late1 (
      .clk(clk), .rst(rst), .start(start_v[3]),
      .a1(s3[63:48]), .a0(s3[47:32]), .b1(s3[31:16]), .b0(s3[15:0]),
      .y3(r3[63:48]), .y2(r3[47:32]), .y1(r3[31:16]), .y0(r3[15:0]),
      .busy(busy_v[3]), .done(done_v[3]), .score(sc3), .perfect(perf_v[3]));
   mul4_fitness_scorer #(.NUM_VECTORS(37), .SETTLE(2), .SEED(RSEED)) u_rand (
      .clk(clk), .rst(rst), .start(start_v[4]),
      .a1(s4[63:48]), .a0(s4[47:32]), .b1(s4[31:16]), .b0(s4[15:0]),
      .y3(r4[63:48]), .y2(r4[47:32]), .y1(r4[31:16]), .y0(r4[15:0]),
      .busy(busy_v[4]), .done(done_v[4]), .score(sc4), .perfect(perf_v[4]));

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] score_of(input int id);
      case (id)
         0: return sc0;
         1: return sc1;
         2: return sc2;
         3: return sc3;
         default: return sc4;
      endcase
   endfunction

   // Entry: {id[2:0], below, score[23:0], done_cycle[23:0]}; below=1 means score must stay under the maximum.
   logic [4:0] prev_done = '0;
   always @(negedge clk) begin
      logic [W-1:0] e;
      int id, mx;
      logic [23:0] act;
      if (prev_done != 0) check("done_width", done_v & prev_done, 0);
      prev_done = rst ? 5'd0 : done_v;
      if (!rst && done_v != 0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", done_v, 0);
         end else begin
            e   = exp_q.pop_front();
            id  = int'(e[51:49]);
            mx  = PER * nv_of(id);
            act = score_of(id);
            check("done_source", done_v, 5'd1 << id);
            check("done_cycle", cyc, e[23:0]);
            if (e[48]) begin
               check("late_below_max", act < 24'(mx), 1);
               check("late_perfect", perf_v[id], 0);
            end else begin
               check("score", act, e[47:24]);
               check("perfect", perf_v[id], e[47:24] == 24'(mx));
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic launch(input int id, input bit push);
      logic [W-1:0] e;
      int below, sc;
      @(negedge clk);
      start_v[id] = 1'b1;
      below = (id == 3);
      sc    = below ? PER * nv_of(id) : model_score(id);
      e = {3'(id), 1'(below), 24'(sc), 24'(cyc + 1 + nv_of(id) * (st_of(id) + 1))};
      if (push) exp_q.push_back(e);
      @(negedge clk);
      start_v[id] = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("run_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic new_masks();
      int r;
      for (int i = 0; i < 16; i++) begin
         for (int l = 0; l < 4; l++) begin
            r = $urandom_range(0, 3);
            case (r)
               0, 3: mask_tab[i][l*16 +: 16] = 16'h0;
               1: mask_tab[i][l*16 +: 16] = 16'h1 << $urandom_range(0, 15);
               default: mask_tab[i][l*16 +: 16] = 16'($urandom);
            endcase
         end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst = 1'b1;
      start_v = '0;
      new_masks();
      repeat (3) @(negedge clk);
      check("rst_busy", busy_v, 0);
      check("rst_done", done_v, 0);
      check("rst_score", sc0, 0);
      check("rst_perfect", perf_v, 0);
      check("rst_stim_default", s0, DSEED);
      check("rst_stim_rand", s4, RSEED);
      rst = 1'b0;

      // ideal run with first-vector stimulus checks
      @(negedge clk);
      start_v[0] = 1'b1;
      exp_q.push_back({3'd0, 1'b0, 24'(model_score(0)), 24'(cyc + 1 + 256 * 2)});
      @(negedge clk);
      start_v[0] = 1'b0;
      check("first_stim", {s0[63:48], s0[47:32], s0[31:16], s0[15:0]}, 64'h0000_0000_0000_0001);
      check("busy_in_run", busy_v[0], 1);
      repeat (2) @(negedge clk);
      check("second_stim", s0, step(DSEED));
      drain(2000);

      // restart attempt mid-run must be ignored
      launch(0, 1);
      repeat (20) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      drain(2000);

      launch(1, 1); drain(2000);
      launch(2, 1); drain(2000);
      launch(3, 1); drain(2000);

      // abort at vector 50: no done, cleared immediately
      launch(0, 0);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", busy_v[0], 0);
      check("abort_score", sc0, 0);
      check("abort_done", done_v[0], 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (600) @(negedge clk);
      launch(0, 1); drain(2000);

      for (int k = 0; k < 4; k++) begin
         new_masks();
         repeat ($urandom_range(0, 5)) @(negedge clk);
         launch(4, 1);
         drain(2000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
